// File: rtl/hex_entry_scroller.sv
// Steps through a small table of hex entries on a seven-segment bank, either
// on debounced key presses or on a fixed dwell timer.
module hex_entry_scroller #(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_ENTRIES     = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000,
  parameter int BLANK_LZ        = 0,
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ENTRIES*NUM_DIGITS*4-1:0] entries,
  input  logic                              key_n,
  input  logic                              auto_mode,
  output logic [NUM_DIGITS*8-1:0]           hex,
  output logic [IW-1:0]                     index,
  output logic                              step_pulse
);

  localparam int EW = NUM_DIGITS * 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCROLL_CYCLES + 1);

  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic          sync1_reg, sync2_reg;
  logic          db_reg;
  logic          press_reg;
  logic [DW-1:0] db_cnt_reg;

  // press_reg fires only on the debounced falling edge of the key
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      db_reg     <= 1'b1;
      db_cnt_reg <= '0;
      press_reg  <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_reg     <= sync2_reg;
        db_cnt_reg <= '0;
        press_reg  <= ~sync2_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  logic          mode_reg;
  logic          mode_change;
  logic          terminal;
  logic          advance;
  logic [SW-1:0] scroll_cnt_reg, scroll_cnt_next;
  logic [IW-1:0] index_reg, index_next;
  logic          step_reg;

  // A press and a terminal count in the same cycle collapse into one advance
  always_comb begin
    mode_change     = (auto_mode != mode_reg);
    terminal        = auto_mode && !mode_change &&
                      (scroll_cnt_reg == SW'(SCROLL_CYCLES - 1));
    advance         = press_reg | terminal;
    scroll_cnt_next = '0;
    if (auto_mode && !mode_change && !advance)
      scroll_cnt_next = scroll_cnt_reg + 1'b1;
    index_next = index_reg;
    if (advance)
      index_next = (index_reg == IW'(NUM_ENTRIES - 1)) ? '0 : index_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    mode_reg <= auto_mode;
    if (rst) begin
      scroll_cnt_reg <= '0;
      index_reg      <= '0;
      step_reg       <= 1'b0;
    end else begin
      scroll_cnt_reg <= scroll_cnt_next;
      index_reg      <= index_next;
      step_reg       <= advance;
    end
  end

  logic [EW-1:0]           entry_arr [NUM_ENTRIES];
  logic [EW-1:0]           entry_sel;
  logic [NUM_DIGITS*8-1:0] hex_next;
  logic [NUM_DIGITS*8-1:0] hex_reg;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign entry_arr[gi] = entries[gi*EW +: EW];
    end
  endgenerate

  assign entry_sel = entry_arr[index_reg];

  // A digit is blanked when it and every digit above it are zero
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       blank;
      assign nib   = entry_sel[gi*4 +: 4];
      assign blank = (BLANK_LZ != 0) && (gi != 0) && (entry_sel[EW-1:gi*4] == '0);
      assign hex_next[gi*8 +: 8] = blank ? 8'hFF : seg7(nib);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      hex_reg <= '1;
    else
      hex_reg <= hex_next;
  end

  assign hex        = hex_reg;
  assign index      = index_reg;
  assign step_pulse = step_reg;

endmodule

// File: doc/hex_entry_scroller.md
HEX_ENTRY_SCROLLER -- requirements
Module: hex_entry_scroller

Interface
REQ-001 The block SHALL accept parameter NUM_DIGITS, default 6, the number of seven-segment digits driven.
REQ-002 The block SHALL accept parameter NUM_ENTRIES, default 4, the number of stored display entries (>=2).
REQ-003 The block SHALL accept parameter DEBOUNCE_CYCLES, default 500000, the stable-input cycles required to accept a key change.
REQ-004 The block SHALL accept parameter SCROLL_CYCLES, default 50000000, the dwell cycles per entry in auto mode.
REQ-005 The block SHALL accept parameter BLANK_LZ, default 0, which when 1 enables leading-zero blanking.
REQ-006 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-007 Port: rst  input  1  synchronous, active-high reset.
REQ-008 Port: entries  input  NUM_ENTRIES*NUM_DIGITS*4  hex nibbles; entry k at bits [k*NUM_DIGITS*4 +: NUM_DIGITS*4]; digit 0 is the least significant nibble.
REQ-009 Port: key_n  input  1  asynchronous, active-low push-button requesting the next entry.
REQ-010 Port: auto_mode  input  1  0 = manual stepping, 1 = timed auto-scroll.
REQ-011 Port: hex  output  NUM_DIGITS*8  active-low segments per digit, {dp,g,f,e,d,c,b,a}; digit d at bits [d*8 +: 8].
REQ-012 Port: index  output  clog2(NUM_ENTRIES)  current entry number.
REQ-013 Port: step_pulse  output  1  one-cycle high on every index advance.

Function
REQ-014 key_n SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Debouncer: counter SHALL count consecutive cycles in which the synchronized key differs from the debounced state, clear when they match, and on reaching DEBOUNCE_CYCLES update the debounced state and clear.
REQ-016 A debounced 1->0 transition (press) SHALL produce a one-cycle internal next request; a release SHALL produce none.
REQ-017 Manual mode: index SHALL advance by one on each next request and otherwise hold.
REQ-018 Auto mode: scroll counter SHALL increment every cycle; at SCROLL_CYCLES-1 index SHALL advance and counter clear to 0.
REQ-019 Auto mode: a next request SHALL advance index and clear the scroll counter; if it coincides with the terminal count, exactly one advance SHALL occur.
REQ-020 Index SHALL wrap from NUM_ENTRIES-1 to 0.
REQ-021 Any change of auto_mode SHALL clear the scroll counter that cycle; in manual mode the scroll counter SHALL stay 0.
REQ-022 step_pulse SHALL be high in the cycle after each index advance, coincident with the new index value.
REQ-023 hex SHALL be registered and reflect the entry selected by the current index one cycle after index changes; entries changes SHALL appear with the same one-cycle latency.
REQ-024 Decoding (active low): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,B=83,C=C6,D=A1,E=86,F=8E (hex); dp always off (bit7=1).
REQ-025 BLANK_LZ=1: zero digits above the most significant nonzero digit SHALL output FF; digit 0 SHALL never be blanked.

Reset
REQ-026 While rst is high: index=0, step_pulse=0, hex all FF, scroll and debounce counters 0, synchronizer flops and debounced state 1 (released).
REQ-027 First cycle after rst deasserts, hex SHALL show entry 0; rst asserted mid-dwell or mid-debounce SHALL abort it with no advance.

Verification (NUM_DIGITS=6, NUM_ENTRIES=2, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10, entries = {24'h090621, 24'h030200})
REQ-028 Reset release, auto_mode=0 -> hex digits 5..0 = C0,B0,C0,A4,C0,C0; index=0; no step_pulse.
REQ-029 key_n low for 10 cycles then high -> exactly one step_pulse, index=1, hex digits 5..0 = C0,90,C0,82,A4,F9.
REQ-030 key_n glitch low 3 cycles -> no advance; second press from index 1 -> index wraps to 0.
REQ-031 auto_mode=1, no key -> step_pulse every 10 cycles, index toggles 0,1,0; debounced press landing on terminal count -> single advance and counter restart.
REQ-032 BLANK_LZ=1, entry 0 -> digit 5 = FF, digits 4..0 = B0,C0,A4,C0,C0; rst asserted mid-dwell -> hex all FF, index 0.
